// File: rtl/csr_pkg.sv
// Shared CSR address map and helpers for the timer bank.
package csr_pkg;

   localparam int unsigned CSR_AW     = 14;
   localparam int unsigned CSR_STRIDE = 8;
   localparam int unsigned PRE_W      = 8;

   localparam logic [CSR_AW-1:0] CSR_TID   = 14'h040;
   localparam logic [CSR_AW-1:0] CSR_TCFG  = 14'h041;
   localparam logic [CSR_AW-1:0] CSR_TVAL  = 14'h042;
   localparam logic [CSR_AW-1:0] CSR_TICLR = 14'h044;

   function automatic logic [CSR_AW-1:0] chan_addr(input logic [CSR_AW-1:0] base,
                                                   input int unsigned idx);
      return base + CSR_AW'(idx * CSR_STRIDE);
   endfunction

   function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                              input logic [31:0] wvalue,
                                              input logic [31:0] wmask);
      return (wvalue & wmask) | (old_val & ~wmask);
   endfunction

endpackage

// File: rtl/csr_timer_bank_if.sv
// CSR access bus: write strobe/address/mask/data out, combinational read data back.
interface csr_timer_bank_if;
   import csr_pkg::*;

   logic              csr_we;
   logic [CSR_AW-1:0] csr_num;
   logic [31:0]       csr_wmask;
   logic [31:0]       csr_wvalue;
   logic [31:0]       csr_rvalue;

   modport master (
      output csr_we, csr_num, csr_wmask, csr_wvalue,
      input  csr_rvalue
   );

   modport slave (
      input  csr_we, csr_num, csr_wmask, csr_wvalue,
      output csr_rvalue
   );

endinterface

// File: rtl/csr_timer_chan.sv
// One timer channel: TCFG register, down-counter and registered interrupt pending bit.
module csr_timer_chan #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             tick_i,
   input  logic             cfg_we_i,
   input  logic             clr_we_i,
   input  logic [CNT_W-1:0] wmask_i,
   input  logic [CNT_W-1:0] wvalue_i,
   output logic [CNT_W-1:0] tcfg_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             load_o,
   output logic             irq_o
);

   logic [CNT_W-1:0] tcfg_q, tcfg_d, cnt_q, cnt_d, tcfg_new;
   logic             irq_q, irq_d, irq_set, irq_clr;

   always_comb begin
      tcfg_new = (wvalue_i & wmask_i) | (tcfg_q & ~wmask_i);
      tcfg_d   = tcfg_q;
      cnt_d    = cnt_q;
      load_o   = cfg_we_i && tcfg_new[0];
      // A config write wins over any count activity on the same edge.
      if (cfg_we_i) begin
         tcfg_d = tcfg_new;
         if (tcfg_new[0]) cnt_d = {tcfg_new[CNT_W-1:2], 2'b00};
      end else if (tcfg_q[0] && tick_i) begin
         if (cnt_q == '0) begin
            cnt_d = tcfg_q[1] ? {tcfg_q[CNT_W-1:2], 2'b00} : '1;
         end else if (cnt_q != '1) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
      irq_set = tcfg_q[0] && tick_i && (cnt_q == '0);
      irq_clr = clr_we_i && wvalue_i[0] && wmask_i[0];
      irq_d   = irq_set | (irq_q & ~irq_clr);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tcfg_q <= '0;
         cnt_q  <= '1;
         irq_q  <= 1'b0;
      end else begin
         tcfg_q <= tcfg_d;
         cnt_q  <= cnt_d;
         irq_q  <= irq_d;
      end
   end

   assign tcfg_o = tcfg_q;
   assign cnt_o  = cnt_q;
   assign irq_o  = irq_q;

endmodule

// File: rtl/csr_timer_bank.sv
// Bank of NTIMER CSR-mapped down-counting timers sharing one prescaler and a TID register.
module csr_timer_bank
   import csr_pkg::*;
#(
   parameter int unsigned NTIMER   = 2,
   parameter int unsigned CNT_W    = 32,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                clk,
   input  logic                resetn,
   csr_timer_bank_if.slave     csr,
   input  logic                timer_stall,
   output logic [NTIMER-1:0]   timer_irq,
   output logic                irq_any
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [31:0]      tid_q, tid_d;
   logic             tick;
   logic [31:0]      rvalue;
   logic [NTIMER-1:0] cfg_we, clr_we, load;
   logic [CNT_W-1:0]  tcfg [NTIMER];
   logic [CNT_W-1:0]  cnt  [NTIMER];

   assign tick = !timer_stall && (pre_q == PRE_LAST);

   always_comb begin
      pre_d = pre_q;
      // Enabling any channel restarts the shared prescale phase.
      if (|load) begin
         pre_d = '0;
      end else if (!timer_stall) begin
         pre_d = tick ? '0 : pre_q + PRE_W'(1);
      end
      tid_d = tid_q;
      if (csr.csr_we && (csr.csr_num == CSR_TID)) begin
         tid_d = apply_mask(tid_q, csr.csr_wvalue, csr.csr_wmask);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pre_q <= '0;
         tid_q <= '0;
      end else begin
         pre_q <= pre_d;
         tid_q <= tid_d;
      end
   end

   for (genvar i = 0; i < NTIMER; i++) begin : g_chan
      assign cfg_we[i] = csr.csr_we && (csr.csr_num == chan_addr(CSR_TCFG, i));
      assign clr_we[i] = csr.csr_we && (csr.csr_num == chan_addr(CSR_TICLR, i));

      csr_timer_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk      (clk),
         .resetn   (resetn),
         .tick_i   (tick),
         .cfg_we_i (cfg_we[i]),
         .clr_we_i (clr_we[i]),
         .wmask_i  (csr.csr_wmask[CNT_W-1:0]),
         .wvalue_i (csr.csr_wvalue[CNT_W-1:0]),
         .tcfg_o   (tcfg[i]),
         .cnt_o    (cnt[i]),
         .load_o   (load[i]),
         .irq_o    (timer_irq[i])
      );
   end

   always_comb begin
      rvalue = '0;
      if (csr.csr_num == CSR_TID) rvalue = tid_q;
      for (int unsigned i = 0; i < NTIMER; i++) begin
         if (csr.csr_num == chan_addr(CSR_TCFG, i)) rvalue = 32'(tcfg[i]);
         if (csr.csr_num == chan_addr(CSR_TVAL, i)) rvalue = 32'(cnt[i]);
      end
   end

   assign csr.csr_rvalue = rvalue;
   assign irq_any        = |timer_irq;

endmodule

// File: tb/tb_csr_timer_bank.sv
// Directed bench: one default-config bank (PRESCALE=1) and one PRESCALE=4, CNT_W=16 bank.
module tb_csr_timer_bank;
   import csr_pkg::*;

   logic       clk = 1'b0;
   logic       rst_a, rst_b, stall_a, stall_b;
   logic [1:0] irq_a;
   logic [0:0] irq_b;
   logic       any_a, any_b;
   int         checks   = 0;
   int         failures = 0;

   csr_timer_bank_if ifa ();
   csr_timer_bank_if ifb ();

   always #5 clk = ~clk;

   csr_timer_bank #(
      .NTIMER   (2),
      .CNT_W    (32),
      .PRESCALE (1)
   ) u_dut_a (
      .clk         (clk),
      .resetn      (rst_a),
      .csr         (ifa),
      .timer_stall (stall_a),
      .timer_irq   (irq_a),
      .irq_any     (any_a)
   );

   csr_timer_bank #(
      .NTIMER   (1),
      .CNT_W    (16),
      .PRESCALE (4)
   ) u_dut_b (
      .clk         (clk),
      .resetn      (rst_b),
      .csr         (ifb),
      .timer_stall (stall_b),
      .timer_irq   (irq_b),
      .irq_any     (any_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input bit b, input logic [13:0] a, input logic [31:0] m,
                     input logic [31:0] v);
      if (!b) begin
         ifa.csr_we = 1'b1; ifa.csr_num = a; ifa.csr_wmask = m; ifa.csr_wvalue = v;
      end else begin
         ifb.csr_we = 1'b1; ifb.csr_num = a; ifb.csr_wmask = m; ifb.csr_wvalue = v;
      end
      step(1);
      ifa.csr_we = 1'b0;
      ifb.csr_we = 1'b0;
   endtask

   task automatic rd_chk(input bit b, input logic [13:0] a, input logic [31:0] exp,
                         input string tag);
      if (!b) ifa.csr_num = a;
      else    ifb.csr_num = a;
      #1;
      check(tag, b ? ifb.csr_rvalue : ifa.csr_rvalue, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; stall_a = 1'b0; stall_b = 1'b0;
      ifa.csr_we = 1'b0; ifa.csr_num = '0; ifa.csr_wmask = '0; ifa.csr_wvalue = '0;
      ifb.csr_we = 1'b0; ifb.csr_num = '0; ifb.csr_wmask = '0; ifb.csr_wvalue = '0;
      step(3);
      rst_a = 1'b1; rst_b = 1'b1;
      step(2);

      // Reset state
      rd_chk(0, CSR_TVAL, 32'hFFFF_FFFF, "rst_tval0");
      rd_chk(0, chan_addr(CSR_TVAL, 1), 32'hFFFF_FFFF, "rst_tval1");
      rd_chk(0, CSR_TCFG, 32'h0, "rst_tcfg0");
      rd_chk(0, chan_addr(CSR_TCFG, 1), 32'h0, "rst_tcfg1");
      rd_chk(0, CSR_TID, 32'h0, "rst_tid");
      check("rst_irq", 32'(irq_a), 32'h0);
      check("rst_any", 32'(any_a), 32'h0);
      rd_chk(1, CSR_TVAL, 32'h0000_FFFF, "rst_tval_b");
      step(1);

      // TID full and masked writes
      wr(0, CSR_TID, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
      rd_chk(0, CSR_TID, 32'hDEAD_BEEF, "tid_full");
      wr(0, CSR_TID, 32'h0000_FFFF, 32'h1234_5678);
      rd_chk(0, CSR_TID, 32'hDEAD_5678, "tid_masked");

      // Unmapped / out-of-range channel
      wr(0, 14'h051, 32'hFFFF_FFFF, 32'h11);
      wr(0, 14'h043, 32'hFFFF_FFFF, 32'hFFFF);
      rd_chk(0, 14'h051, 32'h0, "oor_tcfg2");
      rd_chk(0, 14'h043, 32'h0, "unmapped_rd");
      rd_chk(0, CSR_TICLR, 32'h0, "ticlr_rd");
      rd_chk(0, CSR_TVAL, 32'hFFFF_FFFF, "oor_no_effect");
      rd_chk(0, CSR_TID, 32'hDEAD_5678, "tid_untouched");

      // One-shot, INITVAL=4
      wr(0, CSR_TCFG, 32'hFFFF_FFFF, 32'h11);
      rd_chk(0, CSR_TVAL, 32'h10, "os_load");
      for (int k = 1; k <= 16; k++) begin
         step(1);
         rd_chk(0, CSR_TVAL, 32'(16 - k), "os_count");
         check("os_irq_low", 32'(irq_a[0]), 32'h0);
      end
      step(1);
      check("os_irq_set", 32'(irq_a), 32'h1);
      check("os_any", 32'(any_a), 32'h1);
      rd_chk(0, CSR_TVAL, 32'hFFFF_FFFF, "os_wrap");
      step(3);
      rd_chk(0, CSR_TVAL, 32'hFFFF_FFFF, "os_hold");
      wr(0, CSR_TICLR, 32'hFFFF_FFFE, 32'h1);
      check("ticlr_masked_off", 32'(irq_a), 32'h1);
      wr(0, CSR_TICLR, 32'h1, 32'h1);
      check("ticlr0", 32'(irq_a), 32'h0);
      check("ticlr0_any", 32'(any_a), 32'h0);

      // Set and clear on the same edge
      wr(0, CSR_TCFG, 32'hFFFF_FFFF, 32'h11);
      step(16);
      check("coll_pre", 32'(irq_a), 32'h0);
      wr(0, CSR_TICLR, 32'h1, 32'h1);
      check("coll_set_wins", 32'(irq_a), 32'h1);
      wr(0, CSR_TICLR, 32'h1, 32'h1);
      check("coll_clear_after", 32'(irq_a), 32'h0);

      // Periodic channel 1, INITVAL=2
      wr(0, chan_addr(CSR_TCFG, 1), 32'hFFFF_FFFF, 32'hB);
      rd_chk(0, chan_addr(CSR_TVAL, 1), 32'h8, "per_load");
      step(8);
      rd_chk(0, chan_addr(CSR_TVAL, 1), 32'h0, "per_zero");
      check("per_pre", 32'(irq_a), 32'h0);
      step(1);
      check("per_set", 32'(irq_a), 32'h2);
      rd_chk(0, chan_addr(CSR_TVAL, 1), 32'h8, "per_reload");
      wr(0, chan_addr(CSR_TICLR, 1), 32'h1, 32'h1);
      check("per_clr", 32'(irq_a), 32'h0);
      rd_chk(0, chan_addr(CSR_TVAL, 1), 32'h7, "per_after_clr");
      step(8);
      check("per_set2", 32'(irq_a), 32'h2);
      rd_chk(0, chan_addr(CSR_TVAL, 1), 32'h8, "per_reload2");
      wr(0, chan_addr(CSR_TCFG, 1), 32'h1, 32'h0);
      rd_chk(0, chan_addr(CSR_TCFG, 1), 32'hA, "en_off_tcfg");
      rd_chk(0, chan_addr(CSR_TVAL, 1), 32'h8, "en_off_hold");
      step(12);
      rd_chk(0, chan_addr(CSR_TVAL, 1), 32'h8, "en_off_hold_long");
      wr(0, chan_addr(CSR_TICLR, 1), 32'h1, 32'h1);
      check("en_off_clr", 32'(irq_a), 32'h0);

      // Reset mid-count
      wr(0, CSR_TCFG, 32'hFFFF_FFFF, 32'h11);
      step(11);
      rd_chk(0, CSR_TVAL, 32'h5, "mid_tval5");
      rst_a = 1'b0;
      rd_chk(0, CSR_TVAL, 32'hFFFF_FFFF, "rst_async_tval");
      rd_chk(0, CSR_TCFG, 32'h0, "rst_async_tcfg");
      check("rst_async_irq", 32'(irq_a), 32'h0);
      step(1);
      rst_a = 1'b1;
      step(20);
      rd_chk(0, CSR_TVAL, 32'hFFFF_FFFF, "rst_no_resume");
      rd_chk(0, CSR_TID, 32'h0, "rst_tid_cleared");
      check("rst_no_irq", 32'(irq_a), 32'h0);

      // Mask-only EN toggling preserves INITVAL
      wr(0, CSR_TCFG, 32'hFFFF_FFFF, 32'hC);
      rd_chk(0, CSR_TCFG, 32'hC, "cfg_en0");
      rd_chk(0, CSR_TVAL, 32'hFFFF_FFFF, "cfg_en0_noload");
      wr(0, CSR_TCFG, 32'h1, 32'h1);
      rd_chk(0, CSR_TCFG, 32'hD, "mask_en_on");
      rd_chk(0, CSR_TVAL, 32'hC, "mask_en_load");
      wr(0, CSR_TCFG, 32'h1, 32'h0);
      rd_chk(0, CSR_TCFG, 32'hC, "mask_en_off");
      rd_chk(0, CSR_TVAL, 32'hC, "mask_en_off_hold");

      // PRESCALE=4, INITVAL=1
      wr(1, CSR_TCFG, 32'hFFFF_FFFF, 32'h5);
      rd_chk(1, CSR_TVAL, 32'h4, "ps_load");
      step(3);
      rd_chk(1, CSR_TVAL, 32'h4, "ps_hold3");
      step(1);
      rd_chk(1, CSR_TVAL, 32'h3, "ps_dec4");
      step(15);
      rd_chk(1, CSR_TVAL, 32'h0, "ps_zero");
      check("ps_pre", 32'(irq_b), 32'h0);
      step(1);
      check("ps_irq20", 32'(irq_b), 32'h1);
      check("ps_any", 32'(any_b), 32'h1);
      rd_chk(1, CSR_TVAL, 32'h0000_FFFF, "ps_wrap16");
      wr(1, CSR_TICLR, 32'h1, 32'h1);
      check("ps_clr", 32'(irq_b), 32'h0);

      // Same count with 10 stalled cycles
      wr(1, CSR_TCFG, 32'hFFFF_FFFF, 32'h5);
      step(5);
      rd_chk(1, CSR_TVAL, 32'h3, "stall_start");
      stall_b = 1'b1;
      step(10);
      rd_chk(1, CSR_TVAL, 32'h3, "stall_hold");
      stall_b = 1'b0;
      step(14);
      check("stall_pre", 32'(irq_b), 32'h0);
      rd_chk(1, CSR_TVAL, 32'h0, "stall_zero");
      step(1);
      check("stall_irq30", 32'(irq_b), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csr_timer_bank.md
CSR_TIMER_BANK -- requirements
Module: csr_timer_bank

Interface
REQ-001 Parameter NTIMER, default 2: number of independent timer channels, 1..4.
REQ-002 Parameter CNT_W, default 32: counter width, 8..32; TCFG.INITVAL occupies bits [CNT_W-1:2].
REQ-003 Parameter PRESCALE, default 1: clk cycles per counter decrement, 1..256.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port resetn  in  1: asynchronous, active-low reset.
REQ-006 Port csr_we  in  1: CSR write strobe, one write per asserted cycle.
REQ-007 Port csr_num  in  14: CSR address for both write and read.
REQ-008 Port csr_wmask  in  32: per-bit write mask.
REQ-009 Port csr_wvalue  in  32: write data.
REQ-010 Port csr_rvalue  out  32: combinational read data for csr_num.
REQ-011 Port timer_stall  in  1: debug halt; freezes all counters and the prescaler while high.
REQ-012 Port timer_irq  out  NTIMER: registered per-channel interrupt pending bits.
REQ-013 Port irq_any  out  1: OR of timer_irq.

Function
REQ-014 Channel i SHALL decode TCFG at 0x41+8i, TVAL at 0x42+8i and TICLR at 0x44+8i; TID SHALL sit at 0x40 and be shared.
REQ-015 All writable fields SHALL update as new = (wvalue & wmask) | (old & ~wmask).
REQ-016 TCFG SHALL hold fields {INITVAL, PERIODIC[1], EN[0]}; TID SHALL be a 32-bit read/write register.
REQ-017 TVAL SHALL be read-only and return the zero-extended counter; TICLR SHALL read 0.
REQ-018 Unmapped or out-of-range addresses SHALL read 0, and writes to them SHALL be ignored.
REQ-019 A TCFG write whose masked result has EN=1 SHALL load the counter with {INITVAL_new, 2'b00} at that edge and SHALL reset the prescaler.
REQ-020 With EN=1, stall=0 and a prescaler tick, a counter not equal to all-ones SHALL decrement by 1.
REQ-021 A prescaler tick SHALL occur when the prescale counter reaches PRESCALE-1; the prescale counter then wraps to 0.
REQ-022 On a tick with counter==0: if PERIODIC=1, the counter SHALL reload {INITVAL,00}; otherwise it SHALL wrap to all-ones and then hold.
REQ-023 timer_irq[i] SHALL be set at the edge following a tick at which counter i is 0 and EN=1; setting SHALL be a one-cycle-late registered event.
REQ-024 A TICLR write with masked bit0=1 SHALL clear timer_irq[i].
REQ-025 If a set and a clear hit the same edge, set SHALL win.
REQ-026 A TCFG write SHALL take priority over the decrement or reload at the same edge.
REQ-027 When EN=0 or timer_stall=1, the counter SHALL hold its value and timer_irq SHALL not be set.

Reset
REQ-028 Asserting resetn low SHALL immediately reset all state: TCFG=0, TID=0, prescaler=0, every counter=all-ones (CNT_W bits), timer_irq=0, irq_any=0.
REQ-029 Reset mid-count SHALL abort the count with no pending interrupt left behind; deassertion SHALL be synchronised externally.

Structure
REQ-030 CSR address constants (TID, TCFG/TVAL/TICLR base values, channel stride 8) SHALL live in the shared package csr_pkg.
REQ-031 Per-channel logic SHALL be a sub-module csr_timer_chan, instantiated NTIMER times by generate; the shared prescaler and TID SHALL stay in the top.
REQ-032 csr_rvalue SHALL be a flat mux with no added latency.

Verification
REQ-033 Reset → TVAL0 = 0xFFFFFFFF, timer_irq = 0, and all TCFG/TID registers read 0.
REQ-034 PRESCALE=1: write TCFG0 = 0x00000011 (INITVAL=4, one-shot, EN) → TVAL0 reads 0x10, 0xF, ..., 0; timer_irq[0] rises 17 cycles after the write; TVAL0 then holds 0xFFFFFFFF.
REQ-035 Write TCFG1 = 0x0000000B (INITVAL=2, periodic): the counter cycles 8..0, timer_irq[1] sets every 9 ticks, and a TICLR1 write of 1 drops it one cycle later.
REQ-036 Land the TICLR0 write on the same edge as the set → timer_irq[0] stays 1.
REQ-037 PRESCALE=4, INITVAL=1: TVAL decrements every 4 cycles; holding timer_stall for 10 cycles delays the irq by exactly 10 cycles.
REQ-038 Pulse resetn low mid-count at TVAL=5 → TVAL = all-ones, no irq; write with wmask=0x1 only toggles EN and preserves INITVAL.
